// File: rtl/wb_stage.sv
// wb_stage: writeback stage between the memory-stage pipeline register and the
// register-file write port. Completed results are accepted over valid/ready,
// filtered (non-writing instructions and writes to r0 are dropped), buffered in
// a DEPTH-entry FIFO while the write port is busy, and retired one per cycle.
//
// Optional feature macro: WB_FWD_EN
//   defined   : fwd1/fwd2 compare buffered entries against src1/src2 and
//               forward the youngest matching entry's data.
//   undefined : src1/src2 are ignored, all fwd outputs are tied to 0.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   in_valid / in_ready       memory-stage handshake
//   in_wb_en, in_mem_r_en     write-enable and load-select of the offered result
//   in_dest, in_alu_result,
//   in_mem_data               destination and candidate data
//   port_busy                 write port unavailable this cycle
//   WB_Write_Enable/Dest/Data register-file write port (driven from FIFO head)
//   pending                   buffered-entry count 0..DEPTH
//   src1, src2                decode-stage read addresses
//   fwd1_hit/data, fwd2_hit/data  forwarding results

module wb_stage #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_wb_en,
    input  logic                         in_mem_r_en,
    input  logic [4:0]                   in_dest,
    input  logic [31:0]                  in_alu_result,
    input  logic [31:0]                  in_mem_data,
    input  logic                         port_busy,
    output logic                         WB_Write_Enable,
    output logic [4:0]                   WB_Dest,
    output logic [31:0]                  WB_Data,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    input  logic [4:0]                   src1,
    input  logic [4:0]                   src2,
    output logic                         fwd1_hit,
    output logic                         fwd2_hit,
    output logic [31:0]                  fwd1_data,
    output logic [31:0]                  fwd2_data
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned DEST_W = 5;
    localparam int unsigned DATA_W = 32;

    logic [DEST_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  pending_q, pending_d;

    logic              empty_c;
    logic              push_c;
    logic              pop_c;
    logic [DATA_W-1:0] wdata_c;

    // Handshake and head drive, all derived from registered state
    assign empty_c         = (pending_q == CNT_W'(0));
    assign in_ready        = (pending_q < CNT_W'(DEPTH));
    assign WB_Write_Enable = !empty_c && !port_busy;
    assign WB_Dest         = empty_c ? DEST_W'(0) : dest_q[rd_ptr_q];
    assign WB_Data         = empty_c ? DATA_W'(0) : data_q[rd_ptr_q];
    assign pending         = pending_q;

    // Only register-writing results to a non-zero destination are buffered
    assign push_c  = in_valid && in_ready && in_wb_en && (in_dest != DEST_W'(0));
    assign pop_c   = WB_Write_Enable;
    assign wdata_c = in_mem_r_en ? in_mem_data : in_alu_result;

    // Next-state for pointers and occupancy
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        pending_d = pending_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            pending_d = pending_q - CNT_W'(1);
        end
    end

    // State and storage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q  <= PTR_W'(0);
            wr_ptr_q  <= PTR_W'(0);
            pending_q <= CNT_W'(0);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dest_q[i] <= DEST_W'(0);
                data_q[i] <= DATA_W'(0);
            end
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            pending_q <= pending_d;
            if (push_c) begin
                dest_q[wr_ptr_q] <= in_dest;
                data_q[wr_ptr_q] <= wdata_c;
            end
        end
    end

`ifdef WB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Scan oldest to youngest over live entries so the youngest match wins
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = DATA_W'(0);
        fwd2_data = DATA_W'(0);
        fwd_idx   = PTR_W'(0);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < pending_q) begin
                if ((src1 != DEST_W'(0)) && (dest_q[fwd_idx] == src1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = data_q[fwd_idx];
                end
                if ((src2 != DEST_W'(0)) && (dest_q[fwd_idx] == src2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = data_q[fwd_idx];
                end
            end
        end
    end
`else
    logic unused_src;

    assign unused_src = ^{src1, src2};
    assign fwd1_hit   = 1'b0;
    assign fwd2_hit   = 1'b0;
    assign fwd1_data  = DATA_W'(0);
    assign fwd2_data  = DATA_W'(0);
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a queue-based reference model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_wb_stage;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_wb_en;
    logic              in_mem_r_en;
    logic [4:0]        in_dest;
    logic [31:0]       in_alu_result;
    logic [31:0]       in_mem_data;
    logic              port_busy;
    logic              WB_Write_Enable;
    logic [4:0]        WB_Dest;
    logic [31:0]       WB_Data;
    logic [CNT_W-1:0]  pending;
    logic [4:0]        src1;
    logic [4:0]        src2;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [31:0]       fwd1_data;
    logic [31:0]       fwd2_data;

    int total_cnt  = 0;
    int passed_cnt = 0;

    wb_stage #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_wb_en       (in_wb_en),
        .in_mem_r_en    (in_mem_r_en),
        .in_dest        (in_dest),
        .in_alu_result  (in_alu_result),
        .in_mem_data    (in_mem_data),
        .port_busy      (port_busy),
        .WB_Write_Enable(WB_Write_Enable),
        .WB_Dest        (WB_Dest),
        .WB_Data        (WB_Data),
        .pending        (pending),
        .src1           (src1),
        .src2           (src2),
        .fwd1_hit       (fwd1_hit),
        .fwd2_hit       (fwd2_hit),
        .fwd1_data      (fwd1_data),
        .fwd2_data      (fwd2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) passed_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: list of buffered {dest, data} in program order
    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;
    ent_t mq[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
        end else begin
            automatic bit acc = in_valid && (mq.size() < DEPTH);
            automatic bit pop = (mq.size() > 0) && !port_busy;
            automatic ent_t e;
            if (pop) void'(mq.pop_front());
            if (acc && in_wb_en && in_dest != 5'd0) begin
                e.d = in_dest;
                e.v = in_mem_r_en ? in_mem_data : in_alu_result;
                mq.push_back(e);
            end
        end
    end

    // Compare every cycle against the model
    always @(negedge clk) begin
        automatic bit          e_we  = rst && (mq.size() > 0) && !port_busy;
        automatic logic [4:0]  e_d   = (mq.size() > 0) ? mq[0].d : 5'd0;
        automatic logic [31:0] e_v   = (mq.size() > 0) ? mq[0].v : 32'd0;
        automatic bit          h1 = 1'b0, h2 = 1'b0;
        automatic logic [31:0] f1 = 32'd0, f2 = 32'd0;
`ifdef WB_FWD_EN
        foreach (mq[k]) begin
            if (src1 != 5'd0 && mq[k].d == src1) begin h1 = 1'b1; f1 = mq[k].v; end
            if (src2 != 5'd0 && mq[k].d == src2) begin h2 = 1'b1; f2 = mq[k].v; end
        end
`endif
        chk("m_we",      32'(WB_Write_Enable), 32'(e_we));
        chk("m_dest",    32'(WB_Dest),         32'(e_d));
        chk("m_data",    WB_Data,              e_v);
        chk("m_pending", 32'(pending),         32'(mq.size()));
        chk("m_ready",   32'(in_ready),        32'(mq.size() < DEPTH));
        chk("m_f1hit",   32'(fwd1_hit),        32'(h1));
        chk("m_f2hit",   32'(fwd2_hit),        32'(h2));
        chk("m_f1data",  fwd1_data,            f1);
        chk("m_f2data",  fwd2_data,            f2);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] d, input logic we, input logic mr,
                         input logic [31:0] alu, input logic [31:0] mem);
        in_valid      = 1'b1;
        in_dest       = d;
        in_wb_en      = we;
        in_mem_r_en   = mr;
        in_alu_result = alu;
        in_mem_data   = mem;
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        in_wb_en      = 1'b0;
        in_mem_r_en   = 1'b0;
        in_dest       = 5'd0;
        in_alu_result = 32'd0;
        in_mem_data   = 32'd0;
    endtask

    initial begin
        rst = 1'b0;
        port_busy = 1'b0;
        src1 = 5'd0;
        src2 = 5'd0;
        idle();
        step();
        @(negedge clk);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ready",   32'(in_ready), 32'd1);
        chk("rst_we",      32'(WB_Write_Enable), 32'd0);
        step();
        rst = 1'b1;
        step();

        // Single ALU write, one-cycle latency
        offer(5'd5, 1'b1, 1'b0, 32'h0000_1234, 32'h0);
        step();
        idle();
        @(negedge clk);
        chk("t1_we",   32'(WB_Write_Enable), 32'd1);
        chk("t1_dest", 32'(WB_Dest), 32'd5);
        chk("t1_data", WB_Data, 32'h0000_1234);
        step();
        @(negedge clk);
        chk("t1_pend0", 32'(pending), 32'd0);

        // Load select, then r0 and non-writing filter
        offer(5'd7, 1'b1, 1'b1, 32'h1, 32'hDEAD_BEEF);
        step();
        idle();
        @(negedge clk);
        chk("t2_data", WB_Data, 32'hDEAD_BEEF);
        step();
        offer(5'd0, 1'b1, 1'b0, 32'h55, 32'h0);
        step();
        offer(5'd9, 1'b0, 1'b0, 32'h66, 32'h0);
        step();
        idle();
        @(negedge clk);
        chk("t2_r0_we",   32'(WB_Write_Enable), 32'd0);
        chk("t2_r0_pend", 32'(pending), 32'd0);
        step();

        // Back-pressure with three offers into a two-entry FIFO
        port_busy = 1'b1;
        offer(5'd10, 1'b1, 1'b0, 32'hA0, 32'h0);
        step();
        offer(5'd11, 1'b1, 1'b0, 32'hA1, 32'h0);
        step();
        offer(5'd12, 1'b1, 1'b0, 32'hA2, 32'h0);
        @(negedge clk);
        chk("t3_full_pend",  32'(pending), 32'd2);
        chk("t3_full_ready", 32'(in_ready), 32'd0);
        chk("t3_full_we",    32'(WB_Write_Enable), 32'd0);
        step();
        step();
        port_busy = 1'b0;
        @(negedge clk);
        chk("t3_pop_ready", 32'(in_ready), 32'd0);
        chk("t3_head0",     32'(WB_Dest), 32'd10);
        step();
        @(negedge clk);
        chk("t3_head1", 32'(WB_Dest), 32'd11);
        chk("t3_pend1", 32'(pending), 32'd1);
        step();
        idle();
        @(negedge clk);
        chk("t3_head2", 32'(WB_Dest), 32'd12);
        chk("t3_data2", WB_Data, 32'hA2);
        step();

        // Sustained push+pop with one entry in flight, wrapping the pointers
        for (int i = 0; i < 5; i++) begin
            offer(5'(20 + i), 1'b1, 1'b0, 32'h100 + 32'(i), 32'h0);
            step();
            @(negedge clk);
            chk("t4_pend", 32'(pending), 32'd1);
            chk("t4_head", 32'(WB_Dest), 32'(20 + i));
        end
        idle();
        step();

        // Forwarding of the youngest buffered match
        port_busy = 1'b1;
        offer(5'd3, 1'b1, 1'b0, 32'hA, 32'h0);
        step();
        offer(5'd3, 1'b1, 1'b0, 32'hB, 32'h0);
        step();
        idle();
        src1 = 5'd3;
        src2 = 5'd0;
        @(negedge clk);
`ifdef WB_FWD_EN
        chk("t5_f1hit",  32'(fwd1_hit), 32'd1);
        chk("t5_f1data", fwd1_data, 32'hB);
`else
        chk("t5_f1hit",  32'(fwd1_hit), 32'd0);
        chk("t5_f1data", fwd1_data, 32'h0);
`endif
        chk("t5_f2hit", 32'(fwd2_hit), 32'd0);
        step();
        port_busy = 1'b0;
        step();
        step();
        src1 = 5'd0;

        // Reset with two entries buffered
        port_busy = 1'b1;
        offer(5'd14, 1'b1, 1'b0, 32'hC0, 32'h0);
        step();
        offer(5'd15, 1'b1, 1'b0, 32'hC1, 32'h0);
        step();
        idle();
        @(negedge clk);
        chk("t6_pre_pend", 32'(pending), 32'd2);
        step();
        rst = 1'b0;
        port_busy = 1'b0;
        #1;
        chk("t6_rst_pend",  32'(pending), 32'd0);
        chk("t6_rst_we",    32'(WB_Write_Enable), 32'd0);
        chk("t6_rst_ready", 32'(in_ready), 32'd1);
        step();
        rst = 1'b1;
        offer(5'd5, 1'b1, 1'b0, 32'h0000_1234, 32'h0);
        step();
        idle();
        @(negedge clk);
        chk("t6_after_we",   32'(WB_Write_Enable), 32'd1);
        chk("t6_after_dest", 32'(WB_Dest), 32'd5);
        chk("t6_after_data", WB_Data, 32'h0000_1234);
        step();
        step();

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage that feeds the register-file write port consumed by the decode stage. It accepts completed results from the memory-stage pipeline register over a valid/ready handshake and selects ALU or load data. It buffers results in a small FIFO while the write port is busy and retires at most one register write per cycle. Writes to register 0 and non-writing instructions are filtered before they are buffered.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  memory stage offers a result
- in_ready  out  1  stage can accept this cycle
- in_wb_en  in  1  instruction writes a register
- in_mem_r_en  in  1  result is load data, not ALU data
- in_dest  in  5  destination register
- in_alu_result  in  32  ALU result
- in_mem_data  in  32  load data
- port_busy  in  1  write port unavailable this cycle
- WB_Write_Enable  out  1  register-file write strobe
- WB_Dest  out  5  register-file write address
- WB_Data  out  32  register-file write data
- pending  out  $clog2(DEPTH+1)  buffered-entry count
- src1, src2  in  5 each  decode-stage read addresses
- fwd1_hit, fwd2_hit  out  1 each  pending write matches src1 / src2
- fwd1_data, fwd2_data  out  32 each  forwarded value

## Operation
- Handshake: a transfer occurs on a rising edge where in_valid && in_ready. in_ready = (pending < DEPTH). It does not depend on a same-cycle pop.
- On transfer with in_wb_en=1 and in_dest≠0, push {in_dest, in_mem_r_en ? in_mem_data : in_alu_result}.
- On any other transfer, the handshake completes and nothing is pushed.
- Head drive (combinational):
  - WB_Write_Enable = !empty && !port_busy
  - WB_Dest / WB_Data = head fields when non-empty, else 0
- Pop occurs on an edge where WB_Write_Enable=1.
- Push and pop in the same edge: both take effect and pending is unchanged. This is only possible when pending < DEPTH.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. pending tracks occupancy 0..DEPTH.
- Order is strictly FIFO. No coalescing of writes to the same register.
- Forwarding, with WB_FWD_EN defined:
  - fwdN_hit=1 if any buffered entry has dest == srcN.
  - fwdN_data is the youngest matching entry's data.
  - srcN=0 never hits.
  - Incoming (not yet pushed) data is not forwarded.

## Timing
- Reset values (asynchronous on rst low):
  - pending=0, pointers=0
  - WB_Write_Enable=0, WB_Dest=0, WB_Data=0
  - in_ready=1, fwd*_hit=0, fwd*_data=0
- Reset asserted mid-operation discards all buffered entries. No write strobe occurs while rst is low.
- Latency: a result accepted at edge N, with an empty FIFO and port_busy=0, drives WB_Write_Enable in cycle N+1. The register file writes it at edge N+1.
- Throughput: one write per cycle sustained when port_busy=0.
- Full (pending=DEPTH): in_ready=0 even if a pop is occurring in that cycle.
- Empty with port_busy toggling: no strobe.
- port_busy held high: entries persist indefinitely. Back-pressure reaches in_ready once the FIFO is full.

## Configuration
- WB_FWD_EN defined: forwarding compare and mux logic is built as described above.
- WB_FWD_EN undefined:
  - src1/src2 are ignored.
  - fwd1_hit, fwd2_hit, fwd1_data and fwd2_data are tied to 0.
  - The port list is unchanged.

## Test plan
- Reset then single write: after rst rises, push dest=5, ALU=0x0000_1234, mem_r_en=0 → next cycle WB_Write_Enable=1, WB_Dest=5, WB_Data=0x1234; pending returns to 0.
- Load select and r0 filter:
  - Push dest=7, mem_r_en=1, mem=0xDEAD_BEEF, ALU=0x1 → WB_Data=0xDEADBEEF.
  - Push dest=0, wb_en=1 → handshake completes, no strobe, pending stays 0.
- Back-pressure: hold port_busy=1 and offer 3 results (DEPTH=2):
  - Two are accepted, pending=2, in_ready=0, and the third is held.
  - Release port_busy → writes emerge in order on consecutive cycles, then the third result is accepted.
- Simultaneous push/pop with pending=1 and port_busy=0: pending stays 1 and the head advances. Repeat past DEPTH pushes to confirm pointer wrap keeps order.
- Forwarding (WB_FWD_EN):
  - Buffer dest=3/0xA then dest=3/0xB with port_busy=1, src1=3 → fwd1_hit=1, fwd1_data=0xB.
  - src2=0 → fwd2_hit=0.
  - Without the macro, all fwd outputs are 0.
- Reset mid-operation: with pending=2, pulse rst low for one cycle → pending=0, no strobe, in_ready=1, and the next push behaves as the first.
